ctrl_pipe: RTL
==============

// Module: ctrl_pipe
// PURPOSE
//  Next-gen control unit for the 5-stage MIPS pipeline. Decodes the ID-stage instruction and registers
//  the control bundle into the ID/EX stage. Owns load-use stall detection and the flush bubble.
//  Sequences a multi-cycle mult/div unit (MDU) and stalls mfhi/mflo until HI/LO are valid.
// PARAMETERS
//  ALU_OP_W    6  width of alu_ctrl; ALU codes are the shared include.v macros (add/addu/subu/and/or/slt/sll/lui)
//  MDU_CYCLES  4  EX-side MDU latency in cycles, 1..15
//  HAS_BNE     1  1: decode bne (op 000101); 0: bne is illegal
// PORTS
//  clk             in   1         rising-edge clock
//  reset           in   1         asynchronous, active-low
//  id_instr        in   32        instruction in ID
//  id_valid        in   1         id_instr is real (0 = bubble)
//  flush           in   1         branch/jump redirect; kill ID->EX transfer this edge
//  id_stall        out  1         comb; hold PC and IF/ID this cycle
//  ex_alu_ctrl     out  ALU_OP_W  registered ALU op
//  ex_s_ext        out  1         1 = sign-extend imm
//  ex_s_b          out  1         1 = ALU B from imm
//  ex_mem_write    out  1         store
//  ex_reg_write    out  1         GPR write
//  ex_s_num_write  out  2         dest select 00 rt, 01 rd, 10 $31
//  ex_s_data_write out  2         wb select 00 ALU, 01 mem, 10 pc+4, 11 HI/LO
//  ex_s_npc        out  2         00 pc+4, 01 j/jal, 10 jr, 11 cond. branch
//  ex_br_ne        out  1         cond. branch is bne
//  ex_wr_addr      out  5         resolved dest register (rt/rd/31)
//  ex_mdu_op       out  3         0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo
//  mdu_start       out  1         registered 1-cycle pulse: MDU op entered EX
//  mdu_busy        out  1         MDU counter nonzero
//  illegal         out  1         registered; ID/EX holds an undecodable valid instruction
// BEHAVIOUR
//  - Reset (reset=0, async): all ex_* outputs 0, mdu_start 0, mdu_busy 0, illegal 0, counter 0.
//    Zero bundle = bubble. Reset mid-MDU clears the counter immediately.
//  - Decode (comb, ID): addu/subu/add/and/or/slt/sll/jr/mult/multu/div/divu/mfhi/mflo (funct),
//    addi/addiu/andi/ori/lui/sw/lw/j/jal/beq/bne.
//    R-type: s_num_write 01, reg_write 1; jr: reg_write 0, s_npc 10.
//    andi/ori/lui zero-extend; addi/addiu/sw/lw/beq/bne sign-extend.
//    jal: s_num_write 10, s_data_write 10. mfhi/mflo: s_data_write 11.
//    mult..divu: reg_write 0.
//  - Unknown opcode/funct: decodes to a bubble (all writes 0, s_npc 00); illegal=1 while it sits in EX.
//  - ID/EX update at every clk edge, latency 1. Priority, highest first:
//    1. flush=1 -> bubble.
//    2. id_stall=1 -> bubble; ID holds the instruction.
//    3. id_valid=0 -> bubble.
//    4. Otherwise -> decoded bundle.
//  - Load-use stall: ex_reg_write & ex_s_data_write==01 & ex_wr_addr!=0, and ex_wr_addr matches
//    rs (all users except j/jal/lui/sll) or rt (R-type, beq, bne, sw). Lasts exactly 1 cycle.
//  - MDU counter (4 bits):
//    - Loads MDU_CYCLES on the edge that latches mult/multu/div/divu into EX; mdu_start=1 that cycle.
//    - Otherwise decrements while nonzero; saturates at 0.
//    - mdu_busy = counter!=0.
//  - MDU stall: ID holds any MDU op (incl. mfhi/mflo) while mdu_busy=1. So mfhi directly behind
//    mult stalls exactly MDU_CYCLES cycles.
//  - id_stall = id_valid & ~flush & (load-use | MDU stall).
//  - Flush never aborts a running MDU count. Back-to-back mults serialize via the MDU stall.
//  - Register $0 is never a hazard source. Simultaneous flush+stall -> flush wins, id_stall=0.
// TESTING
//  1. reset=0 mid-run -> all ex_* 0, mdu_busy 0 in the same cycle. Release -> addiu $1,$0,5
//     gives ex_s_b=1, ex_s_ext=1, ex_wr_addr=1 one edge later.
//  2. lw $2,0($1) then addu $3,$2,$4 -> id_stall=1 for exactly 1 cycle, EX bubble, then addu
//     with ex_wr_addr=3. Same with lw $0 -> no stall.
//  3. MDU_CYCLES=4: mult $1,$2 then mflo $5 -> mdu_start 1 cycle, mdu_busy 4 cycles, id_stall 4
//     cycles, then mflo with ex_s_data_write=11.
//  4. flush=1 while ID holds load-use dependent -> id_stall=0, next EX bubble; MDU count
//     continues unaffected.
//  5. Opcode 111111 valid -> illegal=1 one cycle, ex_reg_write=0, ex_mem_write=0.
//     HAS_BNE=0 with bne -> illegal=1.
//  6. jal 0x100 -> ex_s_npc=01, ex_s_num_write=10, ex_wr_addr=31.
//     beq/bne -> ex_s_npc=11, ex_br_ne 0/1.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: groups the ID-side request signals and the registered ID/EX
// control bundle that the pipeline control unit produces. The master side is
// the pipeline datapath (drives the ID instruction and redirects); the slave
// side is the control unit itself.
interface ctrl_pipe_if #(
    parameter int ALU_OP_W = 6
);
    logic [31:0]         id_instr;
    logic                id_valid;
    logic                flush;
    logic                id_stall;
    logic [ALU_OP_W-1:0] ex_alu_ctrl;
    logic                ex_s_ext;
    logic                ex_s_b;
    logic                ex_mem_write;
    logic                ex_reg_write;
    logic [1:0]          ex_s_num_write;
    logic [1:0]          ex_s_data_write;
    logic [1:0]          ex_s_npc;
    logic                ex_br_ne;
    logic [4:0]          ex_wr_addr;
    logic [2:0]          ex_mdu_op;
    logic                mdu_start;
    logic                mdu_busy;
    logic                illegal;

    modport master (
        output id_instr, id_valid, flush,
        input  id_stall, ex_alu_ctrl, ex_s_ext, ex_s_b, ex_mem_write, ex_reg_write,
               ex_s_num_write, ex_s_data_write, ex_s_npc, ex_br_ne, ex_wr_addr,
               ex_mdu_op, mdu_start, mdu_busy, illegal
    );

    modport slave (
        input  id_instr, id_valid, flush,
        output id_stall, ex_alu_ctrl, ex_s_ext, ex_s_b, ex_mem_write, ex_reg_write,
               ex_s_num_write, ex_s_data_write, ex_s_npc, ex_br_ne, ex_wr_addr,
               ex_mdu_op, mdu_start, mdu_busy, illegal
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control unit for the 5-stage MIPS pipeline. Decodes the ID-stage
// instruction, registers the control bundle into ID/EX, detects load-use
// hazards, inserts flush bubbles and sequences the multi-cycle mult/div unit
// so that mfhi/mflo (and further MDU ops) wait until HI/LO are valid.
// reset is asynchronous and active-low.
module ctrl_pipe #(
    parameter int ALU_OP_W   = 6,
    parameter int MDU_CYCLES = 4,
    parameter int HAS_BNE    = 1
) (
    input  logic       clk,
    input  logic       reset,
    ctrl_pipe_if.slave bus
);

    // ALU operation codes shared with the EX-stage ALU; 0 is reserved for the bubble.
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_ADDU = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SUBU = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_LUI  = ALU_OP_W'(8);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;

    localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES);

    typedef struct packed {
        logic [ALU_OP_W-1:0] aluCtrl;
        logic                sExt;
        logic                sB;
        logic                memWrite;
        logic                regWrite;
        logic [1:0]          sNumWrite;
        logic [1:0]          sDataWrite;
        logic [1:0]          sNpc;
        logic                brNe;
        logic [4:0]          wrAddr;
        logic [2:0]          mduOp;
    } bundle_t;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unusedShamt;

    bundle_t    dec;
    logic       decLegal;
    logic       usesRs;
    logic       usesRt;
    logic       isMduCalc;

    logic       loadUse;
    logic       mduStall;
    logic       idStall;

    bundle_t    ex_q;
    bundle_t    ex_d;
    logic       illegal_q;
    logic       illegal_d;
    logic       mduStart_q;
    logic       mduStart_d;
    logic [3:0] mduCount_q;
    logic [3:0] mduCount_d;

    assign opcode      = bus.id_instr[31:26];
    assign rs          = bus.id_instr[25:21];
    assign rt          = bus.id_instr[20:16];
    assign rd          = bus.id_instr[15:11];
    assign funct       = bus.id_instr[5:0];
    assign unusedShamt = ^bus.id_instr[10:6];

    // Decode the ID instruction into a control bundle; anything unknown collapses to a bubble.
    always_comb begin
        dec      = '0;
        decLegal = 1'b0;
        usesRs   = 1'b0;
        usesRt   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                decLegal      = 1'b1;
                usesRs        = 1'b1;
                usesRt        = 1'b1;
                dec.sNumWrite = 2'b01;
                dec.regWrite  = 1'b1;
                case (funct)
                    F_ADD:  dec.aluCtrl = ALU_ADD;
                    F_ADDU: dec.aluCtrl = ALU_ADDU;
                    F_SUBU: dec.aluCtrl = ALU_SUBU;
                    F_AND:  dec.aluCtrl = ALU_AND;
                    F_OR:   dec.aluCtrl = ALU_OR;
                    F_SLT:  dec.aluCtrl = ALU_SLT;
                    F_SLL: begin
                        dec.aluCtrl = ALU_SLL;
                        usesRs      = 1'b0;
                    end
                    F_JR: begin
                        dec.regWrite = 1'b0;
                        dec.sNpc     = 2'b10;
                    end
                    F_MULT: begin
                        dec.regWrite = 1'b0;
                        dec.mduOp    = 3'd1;
                    end
                    F_MULTU: begin
                        dec.regWrite = 1'b0;
                        dec.mduOp    = 3'd2;
                    end
                    F_DIV: begin
                        dec.regWrite = 1'b0;
                        dec.mduOp    = 3'd3;
                    end
                    F_DIVU: begin
                        dec.regWrite = 1'b0;
                        dec.mduOp    = 3'd4;
                    end
                    F_MFHI: begin
                        dec.sDataWrite = 2'b11;
                        dec.mduOp      = 3'd5;
                    end
                    F_MFLO: begin
                        dec.sDataWrite = 2'b11;
                        dec.mduOp      = 3'd6;
                    end
                    default: decLegal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                decLegal     = 1'b1;
                usesRs       = 1'b1;
                dec.aluCtrl  = (opcode == OP_ADDI) ? ALU_ADD : ALU_ADDU;
                dec.sExt     = 1'b1;
                dec.sB       = 1'b1;
                dec.regWrite = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                decLegal     = 1'b1;
                usesRs       = 1'b1;
                dec.aluCtrl  = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                dec.sB       = 1'b1;
                dec.regWrite = 1'b1;
            end
            OP_LUI: begin
                decLegal     = 1'b1;
                dec.aluCtrl  = ALU_LUI;
                dec.sB       = 1'b1;
                dec.regWrite = 1'b1;
            end
            OP_LW: begin
                decLegal       = 1'b1;
                usesRs         = 1'b1;
                dec.aluCtrl    = ALU_ADDU;
                dec.sExt       = 1'b1;
                dec.sB         = 1'b1;
                dec.regWrite   = 1'b1;
                dec.sDataWrite = 2'b01;
            end
            OP_SW: begin
                decLegal     = 1'b1;
                usesRs       = 1'b1;
                usesRt       = 1'b1;
                dec.aluCtrl  = ALU_ADDU;
                dec.sExt     = 1'b1;
                dec.sB       = 1'b1;
                dec.memWrite = 1'b1;
            end
            OP_J: begin
                decLegal = 1'b1;
                dec.sNpc = 2'b01;
            end
            OP_JAL: begin
                decLegal       = 1'b1;
                dec.sNpc       = 2'b01;
                dec.regWrite   = 1'b1;
                dec.sNumWrite  = 2'b10;
                dec.sDataWrite = 2'b10;
            end
            OP_BEQ: begin
                decLegal    = 1'b1;
                usesRs      = 1'b1;
                usesRt      = 1'b1;
                dec.aluCtrl = ALU_SUBU;
                dec.sExt    = 1'b1;
                dec.sNpc    = 2'b11;
            end
            OP_BNE: begin
                if (HAS_BNE != 0) begin
                    decLegal    = 1'b1;
                    usesRs      = 1'b1;
                    usesRt      = 1'b1;
                    dec.aluCtrl = ALU_SUBU;
                    dec.sExt    = 1'b1;
                    dec.sNpc    = 2'b11;
                    dec.brNe    = 1'b1;
                end
            end
            default: decLegal = 1'b0;
        endcase

        if (!decLegal) begin
            dec    = '0;
            usesRs = 1'b0;
            usesRt = 1'b0;
        end else begin
            case (dec.sNumWrite)
                2'b01:   dec.wrAddr = rd;
                2'b10:   dec.wrAddr = 5'd31;
                default: dec.wrAddr = rt;
            endcase
        end
    end

    // Hazard detection: load-use against the load sitting in EX, and MDU ops waiting on HI/LO.
    always_comb begin
        isMduCalc = (dec.mduOp != 3'd0) && (dec.mduOp <= 3'd4);
        loadUse   = 1'b0;
        if (ex_q.regWrite && (ex_q.sDataWrite == 2'b01) && (ex_q.wrAddr != 5'd0)) begin
            loadUse = (usesRs && (rs == ex_q.wrAddr)) || (usesRt && (rt == ex_q.wrAddr));
        end
        mduStall = (dec.mduOp != 3'd0) && (mduCount_q != 4'd0);
        idStall  = bus.id_valid && !bus.flush && (loadUse || mduStall);
    end

    // Next ID/EX contents: flush, stall and empty ID all turn into a bubble; the MDU count runs regardless.
    always_comb begin
        ex_d       = '0;
        illegal_d  = 1'b0;
        mduStart_d = 1'b0;
        if (!bus.flush && !idStall && bus.id_valid) begin
            ex_d       = dec;
            illegal_d  = !decLegal;
            mduStart_d = isMduCalc;
        end
        if (mduStart_d) begin
            mduCount_d = MDU_LOAD;
        end else if (mduCount_q != 4'd0) begin
            mduCount_d = mduCount_q - 4'd1;
        end else begin
            mduCount_d = 4'd0;
        end
    end

    // ID/EX pipeline register and MDU counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q       <= '0;
            illegal_q  <= 1'b0;
            mduStart_q <= 1'b0;
            mduCount_q <= 4'd0;
        end else begin
            ex_q       <= ex_d;
            illegal_q  <= illegal_d;
            mduStart_q <= mduStart_d;
            mduCount_q <= mduCount_d;
        end
    end

    assign bus.id_stall        = idStall;
    assign bus.ex_alu_ctrl     = ex_q.aluCtrl;
    assign bus.ex_s_ext        = ex_q.sExt;
    assign bus.ex_s_b          = ex_q.sB;
    assign bus.ex_mem_write    = ex_q.memWrite;
    assign bus.ex_reg_write    = ex_q.regWrite;
    assign bus.ex_s_num_write  = ex_q.sNumWrite;
    assign bus.ex_s_data_write = ex_q.sDataWrite;
    assign bus.ex_s_npc        = ex_q.sNpc;
    assign bus.ex_br_ne        = ex_q.brNe;
    assign bus.ex_wr_addr      = ex_q.wrAddr;
    assign bus.ex_mdu_op       = ex_q.mduOp;
    assign bus.mdu_start       = mduStart_q;
    assign bus.mdu_busy        = (mduCount_q != 4'd0);
    assign bus.illegal         = illegal_q;

endmodule
